host_reg_bridge: RTL and testbench
==================================

HOST_REG_BRIDGE -- requirements
Module: host_reg_bridge

Interface
REQ-001 Parameter N_CFG, default 14: number of 16-bit host-writable config registers (1..64).
REQ-002 Parameter N_RES, default 8: number of 16-bit result registers (2..64).
REQ-003 Parameter CLK_HZ, default 50000000: clk frequency.
REQ-004 Parameter SCAN_HZ, default 1000: 7-segment digit scan rate.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 nRESET  in  1  asynchronous, active-low reset.
REQ-007 HOST_nCS, HOST_nWE, HOST_nOE  in  1 each  asynchronous host strobes, active low.
REQ-008 HOST_ADD  in  21  host byte address; bit 20 selects SRAM window, bits 19:0 register offset.
REQ-009 HDI  in  16  host write data.
REQ-010 HDO  out  16  host read data, registered.
REQ-011 proc_status  in  4  datapath status; 0 IDLE, 1 BUSY, 2 COMPLETE.
REQ-012 res_din  in  16*N_RES  datapath results; halfword i = bits 16i+15:16i.
REQ-013 cfg_dout  out  16*N_CFG  config registers concatenated, register i at bits 16i+15:16i.
REQ-014 proc_cmd  out  4  command to datapath.
REQ-015 SEG_COM  out  6  digit enables, active low, one-hot-zero.
REQ-016 SEG_DATA  out  8  segments {a,b,c,d,e,f,g,dp}, active high, dp always 0.

Function
REQ-017 Address map (HOST_ADD[20]=0): CFG[i] at 0x00000+2i; CMD at 0x01000 (R/W); STATUS at 0x01002 (RO); DISP at 0x01004 (R/W); RES[i] at 0x03000+2i (RO).
REQ-018 HOST_nCS/nWE/nOE pass through 2-flop synchronizers before use; HOST_ADD and HDI sampled unsynchronized at commit.
REQ-019 A write commits exactly once, on the cycle the synchronized nWE is first seen low (falling-edge detect) with synchronized nCS low and nOE high; holding nWE low causes no further commits.
REQ-020 Writes to RES, STATUS, unmapped offsets, or with HOST_ADD[20]=1 are ignored.
REQ-021 While synchronized nCS and nOE are low, HDO updates every cycle to the addressed register (one-cycle latency); unmapped or HOST_ADD[20]=1 reads return 0x0000; otherwise HDO holds.
REQ-022 Completion event = cycle proc_status becomes 2 having been not-2 the previous cycle.
REQ-023 On a completion event: RES[i] <= res_din halfword i for all i; CMD <= 0; STATUS.done <= 1; STATUS.count (bits 15:8) increments modulo 256.
REQ-024 Completion event and host CMD write in the same cycle: completion wins, host write discarded.
REQ-025 Host write of any value to CMD clears STATUS.done.
REQ-026 STATUS = {count[7:0], 3'b0, done, proc_status[3:0]}.
REQ-027 proc_cmd = 2 (ACK) whenever proc_status==2, else CMD[3:0], combinational.
REQ-028 Scan tick every CLK_HZ/SCAN_HZ clk cycles from a free-running counter; no derived clock.
REQ-029 On each tick, digit index advances 0..5 and wraps to 0; digit d drives SEG_COM bit (5-d) low.
REQ-030 Displayed 24-bit value = {RES[2k+1][7:0], RES[2k]} with k = DISP[4:0] mod (N_RES/2); digit d shows nibble d.
REQ-031 Nibble decode covers 0-F (hex glyphs A,b,C,d,E,F); 0 encodes 7'b1111110.

Reset
REQ-032 On nRESET low: all CFG, CMD, DISP, RES, STATUS.done, count, HDO = 0; synchronizers = 1 (inactive); scan counter and digit index = 0; SEG_COM = 6'b111111; SEG_DATA = 0.
REQ-033 Reset mid-write or mid-read aborts the transfer; no commit occurs on reset release while nWE is still low.
REQ-034 Reset during BUSY leaves proc_cmd = 0 until datapath status changes.

Structure
REQ-035 Shared package holds address offsets, PROC_STATUS_* and PROC_CMD_* codes, STATUS field positions, and the 7-segment hex glyph table.
REQ-036 One sub-module, seg7_scan (tick counter, digit index, decode), instantiated once; register file and host logic in host_reg_bridge.

Verification
REQ-037 Write 0x1234 to 0x00000, 0xABCD to 0x00002 with nWE held low 10 cycles -> cfg_dout[31:0]=0xABCD1234, exactly one commit each.
REQ-038 Write CMD=1; drive proc_status 1 then 2 with res_din halfword0=0x00F5 -> RES[0]=0x00F5, CMD=0, proc_cmd=2 while status=2, STATUS=0x0112.
REQ-039 Completion event coincides with CMD write 0x0003 -> CMD=0, done=1.
REQ-040 Read 0x03000 after REQ-038 -> HDO=0x00F5 one cycle after strobes sync; read 0x00100 -> HDO=0x0000.
REQ-041 RES[1]=0x00AB, RES[0]=0xCDEF, DISP=0, SCAN tick shortened -> digits 0..5 show F,E,d,C,b,A, SEG_COM sequence 011111..111110 then wraps.
REQ-042 Assert nRESET during nWE low, release while still low -> no commit, all outputs at reset values.

Source files
------------

// File: rtl/host_reg_bridge_pkg.sv
// host_reg_bridge_pkg: address map, datapath codes, status layout and 7-segment glyphs
package host_reg_bridge_pkg;
  localparam logic [19:0] OFF_CFG    = 20'h00000;
  localparam logic [19:0] OFF_CMD    = 20'h01000;
  localparam logic [19:0] OFF_STATUS = 20'h01002;
  localparam logic [19:0] OFF_DISP   = 20'h01004;
  localparam logic [19:0] OFF_RES    = 20'h03000;
  typedef enum logic [3:0] {
    PROC_STATUS_IDLE     = 4'd0,
    PROC_STATUS_BUSY     = 4'd1,
    PROC_STATUS_COMPLETE = 4'd2
  } proc_status_e;
  typedef enum logic [3:0] {
    PROC_CMD_NONE = 4'd0,
    PROC_CMD_ACK  = 4'd2
  } proc_cmd_e;
  localparam int STATUS_PS_LSB   = 0;
  localparam int STATUS_DONE_BIT = 4;
  localparam int STATUS_CNT_LSB  = 8;
  // segments {a,b,c,d,e,f,g}, index = nibble value
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  function automatic logic [15:0] status_word(input logic [7:0] cnt, input logic done, input logic [3:0] ps);
    return (16'(cnt) << STATUS_CNT_LSB) | (16'(done) << STATUS_DONE_BIT) | (16'(ps) << STATUS_PS_LSB);
  endfunction
endpackage

// File: rtl/host_reg_bridge_if.sv
// host_reg_bridge_if: asynchronous SRAM-style host bus
interface host_reg_bridge_if;
  logic        HOST_nCS;
  logic        HOST_nWE;
  logic        HOST_nOE;
  logic [20:0] HOST_ADD;
  logic [15:0] HDI;
  logic [15:0] HDO;
  modport master (output HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI, input HDO);
  modport slave  (input HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI, output HDO);
endinterface

// File: rtl/host_reg_bridge_seg7_scan.sv
// seg7_scan: multiplexed six-digit hex display driven by a divided scan tick
module seg7_scan import host_reg_bridge_pkg::*; #(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [23:0] value,
  output logic [5:0]  seg_com,
  output logic [7:0]  seg_data
);
  localparam int DIV = (CLK_HZ / SCAN_HZ) < 1 ? 1 : CLK_HZ / SCAN_HZ;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [5:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;
  logic          tick;
  logic [3:0]    nib;
  always_comb begin
    tick   = cnt_q == CW'(DIV - 1);
    nib    = 4'(value >> {dig_q, 2'b00});
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    dig_d  = tick ? (dig_q == 3'd5 ? 3'd0 : dig_q + 3'd1) : dig_q;
    com_d  = tick ? ~(6'b100000 >> dig_q) : com_q;
    data_d = tick ? {SEG_GLYPH[nib], 1'b0} : data_q;
  end
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      cnt_q  <= '0;
      dig_q  <= '0;
      com_q  <= 6'b111111;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      com_q  <= com_d;
      data_q <= data_d;
    end
  assign seg_com  = com_q;
  assign seg_data = data_q;
endmodule

// File: rtl/host_reg_bridge.sv
// host_reg_bridge: host-visible config/command/result registers for a datapath,
// with a 7-segment view of a selected result pair.
module host_reg_bridge import host_reg_bridge_pkg::*; #(
  parameter int N_CFG   = 14,
  parameter int N_RES   = 8,
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                 clk,
  input  logic                 nRESET,
  host_reg_bridge_if.slave     host,
  input  logic [3:0]           proc_status,
  input  logic [16*N_RES-1:0]  res_din,
  output logic [16*N_CFG-1:0]  cfg_dout,
  output logic [3:0]           proc_cmd,
  output logic [5:0]           SEG_COM,
  output logic [7:0]           SEG_DATA
);
  localparam int CI = N_CFG > 1 ? $clog2(N_CFG) : 1;
  localparam int RI = $clog2(N_RES);
  localparam int NP = N_RES / 2;
  logic [2:0]  s1_q, s1_d, s2_q, s2_d;
  logic        prev_q, prev_d, ps2_q, ps2_d, done_q, done_d;
  logic [1:0]  rdy_q, rdy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] cmd_q, cmd_d, disp_q, disp_d, hdo_q, hdo_d;
  logic [15:0] cfg_q [N_CFG];
  logic [15:0] cfg_d [N_CFG];
  logic [15:0] res_q [N_RES];
  logic [15:0] res_d [N_RES];
  logic        cs_s, we_s, oe_s, win, wr, comp, cfg_hit, res_hit;
  logic [19:0] off, cfg_off, res_off;
  logic [15:0] rdata;
  logic [RI-1:0] lo_idx, hi_idx;
  always_comb begin
    cs_s    = s2_q[2];
    we_s    = s2_q[1];
    oe_s    = s2_q[0];
    win     = host.HOST_ADD[20];
    off     = host.HOST_ADD[19:0];
    cfg_off = off - OFF_CFG;
    res_off = off - OFF_RES;
    cfg_hit = !win && !cfg_off[0] && cfg_off[19:1] < 19'(N_CFG);
    res_hit = !win && off >= OFF_RES && !res_off[0] && res_off[19:1] < 19'(N_RES);
    wr      = !cs_s && !we_s && prev_q && oe_s && !win;
    comp    = proc_status == PROC_STATUS_COMPLETE && !ps2_q;
    rdata   = win ? 16'h0000 :
              cfg_hit ? cfg_q[cfg_off[CI:1]] :
              off == OFF_CMD ? cmd_q :
              off == OFF_STATUS ? status_word(cnt_q, done_q, proc_status) :
              off == OFF_DISP ? disp_q :
              res_hit ? res_q[res_off[RI:1]] : 16'h0000;
    s1_d    = {host.HOST_nCS, host.HOST_nWE, host.HOST_nOE};
    s2_d    = s1_q;
    rdy_d   = {rdy_q[0], 1'b1};
    // nWE is only treated as previously high once the synchronizer holds real pin samples
    prev_d  = we_s && rdy_q[1];
    ps2_d   = proc_status == PROC_STATUS_COMPLETE;
    cfg_d   = cfg_q;
    res_d   = res_q;
    cmd_d   = cmd_q;
    disp_d  = disp_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    hdo_d   = (!cs_s && !oe_s) ? rdata : hdo_q;
    if (wr && cfg_hit) cfg_d[cfg_off[CI:1]] = host.HDI;
    if (wr && off == OFF_DISP) disp_d = host.HDI;
    if (wr && off == OFF_CMD) begin
      cmd_d  = host.HDI;
      done_d = 1'b0;
    end
    if (comp) begin
      for (int i = 0; i < N_RES; i++) res_d[i] = res_din[16*i +: 16];
      cmd_d  = '0;
      done_d = 1'b1;
      cnt_d  = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      s1_q   <= 3'b111;
      s2_q   <= 3'b111;
      rdy_q  <= '0;
      prev_q <= 1'b0;
      // status already COMPLETE across reset is not a fresh completion
      ps2_q  <= 1'b1;
      for (int i = 0; i < N_CFG; i++) cfg_q[i] <= '0;
      for (int i = 0; i < N_RES; i++) res_q[i] <= '0;
      cmd_q  <= '0;
      disp_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      hdo_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rdy_q  <= rdy_d;
      prev_q <= prev_d;
      ps2_q  <= ps2_d;
      cfg_q  <= cfg_d;
      res_q  <= res_d;
      cmd_q  <= cmd_d;
      disp_q <= disp_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      hdo_q  <= hdo_d;
    end
  always_comb begin
    for (int i = 0; i < N_CFG; i++) cfg_dout[16*i +: 16] = cfg_q[i];
    proc_cmd = proc_status == PROC_STATUS_COMPLETE ? PROC_CMD_ACK : cmd_q[3:0];
    lo_idx   = RI'((32'(disp_q[4:0]) % NP) * 2);
    hi_idx   = lo_idx + RI'(1);
  end
  assign host.HDO = hdo_q;
  seg7_scan #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_scan (
    .clk      (clk),
    .nRESET   (nRESET),
    .value    ({res_q[hi_idx][7:0], res_q[lo_idx]}),
    .seg_com  (SEG_COM),
    .seg_data (SEG_DATA)
  );
endmodule

// File: tb/tb_host_reg_bridge.sv
// tb_host_reg_bridge: directed host transfers, completion handshakes, display scan and reset abort
module tb_host_reg_bridge;
  logic         clk = 1'b0;
  logic         nRESET = 1'b0;
  logic [3:0]   proc_status = 4'd0;
  logic [127:0] res_din = '0;
  logic [223:0] cfg_dout;
  logic [3:0]   proc_cmd;
  logic [5:0]   SEG_COM;
  logic [7:0]   SEG_DATA;
  logic [15:0]  rv;
  int total = 0;
  int bad = 0;
  logic [5:0] com_exp [6] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
  logic [7:0] seg_exp [6] = '{8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE};
  host_reg_bridge_if hif();
  host_reg_bridge #(.N_CFG(14), .N_RES(8), .CLK_HZ(50), .SCAN_HZ(10)) dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .host        (hif),
    .proc_status (proc_status),
    .res_din     (res_din),
    .cfg_dout    (cfg_dout),
    .proc_cmd    (proc_cmd),
    .SEG_COM     (SEG_COM),
    .SEG_DATA    (SEG_DATA)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [20:0] a, input logic [15:0] d);
    @(negedge clk);
    hif.HOST_ADD = a;
    hif.HDI = d;
    hif.HOST_nCS = 1'b0;
    hif.HOST_nWE = 1'b0;
    repeat (5) @(negedge clk);
    hif.HDI = ~d;
    repeat (5) @(negedge clk);
    hif.HOST_nWE = 1'b1;
    hif.HOST_nCS = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic rd(input logic [20:0] a, output logic [15:0] d);
    @(negedge clk);
    hif.HOST_ADD = a;
    hif.HOST_nCS = 1'b0;
    hif.HOST_nOE = 1'b0;
    repeat (3) @(negedge clk);
    d = hif.HDO;
    hif.HOST_nOE = 1'b1;
    hif.HOST_nCS = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic sync_d0(input string tag);
    logic [5:0] p;
    bit hit = 1'b0;
    p = SEG_COM;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = SEG_COM == 6'b011111 && p != 6'b011111;
      p = SEG_COM;
    end
    chk(tag, {31'b0, hit}, 32'd1);
  endtask
  initial begin
    hif.HOST_nCS = 1'b1;
    hif.HOST_nWE = 1'b1;
    hif.HOST_nOE = 1'b1;
    hif.HOST_ADD = '0;
    hif.HDI = '0;
    repeat (3) @(negedge clk);
    chk("rst_com", 32'(SEG_COM), 32'h3F);
    chk("rst_seg", 32'(SEG_DATA), 32'h00);
    chk("rst_hdo", 32'(hif.HDO), 32'h0000);
    chk("rst_cmd", 32'(proc_cmd), 32'h0);
    chk("rst_cfg", {31'b0, |cfg_dout}, 32'd0);
    nRESET = 1'b1;
    repeat (2) @(negedge clk);
    wr(21'h000000, 16'h1234);
    wr(21'h000002, 16'hABCD);
    chk("cfg01", cfg_dout[31:0], 32'hABCD1234);
    wr(21'h100000, 16'h5555);
    chk("win_wr_ignored", cfg_dout[31:0], 32'hABCD1234);
    wr(21'h00001A, 16'hBEEF);
    chk("cfg13", 32'(cfg_dout[223:208]), 32'hBEEF);
    rd(21'h000002, rv);
    chk("rd_cfg1", 32'(rv), 32'hABCD);
    wr(21'h001000, 16'h0001);
    chk("cmd1", 32'(proc_cmd), 32'h1);
    proc_status = 4'd1;
    repeat (2) @(negedge clk);
    res_din[15:0] = 16'h00F5;
    proc_status = 4'd2;
    @(negedge clk);
    chk("ack", 32'(proc_cmd), 32'h2);
    rd(21'h001002, rv);
    chk("status1", 32'(rv), 32'h0112);
    rd(21'h001000, rv);
    chk("cmd_cleared", 32'(rv), 32'h0000);
    proc_status = 4'd0;
    @(negedge clk);
    chk("cmd_after", 32'(proc_cmd), 32'h0);
    rd(21'h003000, rv);
    chk("rd_res0", 32'(rv), 32'h00F5);
    rd(21'h000100, rv);
    chk("rd_unmapped", 32'(rv), 32'h0000);
    rd(21'h103000, rv);
    chk("rd_window", 32'(rv), 32'h0000);
    wr(21'h003000, 16'h1111);
    rd(21'h003000, rv);
    chk("res_ro", 32'(rv), 32'h00F5);
    wr(21'h001000, 16'h0000);
    rd(21'h001002, rv);
    chk("done_clr", 32'(rv), 32'h0100);
    proc_status = 4'd1;
    @(negedge clk);
    hif.HOST_ADD = 21'h001000;
    hif.HDI = 16'h0003;
    hif.HOST_nCS = 1'b0;
    hif.HOST_nWE = 1'b0;
    repeat (2) @(negedge clk);
    proc_status = 4'd2;
    repeat (5) @(negedge clk);
    proc_status = 4'd0;
    hif.HOST_nWE = 1'b1;
    hif.HOST_nCS = 1'b1;
    repeat (3) @(negedge clk);
    chk("race_cmd", 32'(proc_cmd), 32'h0);
    rd(21'h001002, rv);
    chk("race_status", 32'(rv), 32'h0210);
    res_din[31:0] = 32'h00AB_CDEF;
    proc_status = 4'd2;
    repeat (2) @(negedge clk);
    proc_status = 4'd0;
    rd(21'h003002, rv);
    chk("rd_res1", 32'(rv), 32'h00AB);
    repeat (35) @(negedge clk);
    sync_d0("scan_sync");
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("com_d%0d", d), 32'(SEG_COM), 32'(com_exp[d]));
      chk($sformatf("seg_d%0d", d), 32'(SEG_DATA), 32'(seg_exp[d]));
      repeat (5) @(negedge clk);
    end
    chk("com_wrap", 32'(SEG_COM), 32'h1F);
    chk("seg_wrap", 32'(SEG_DATA), 32'h8E);
    wr(21'h001004, 16'h0001);
    rd(21'h001004, rv);
    chk("rd_disp", 32'(rv), 32'h0001);
    repeat (35) @(negedge clk);
    chk("disp1_zero", 32'(SEG_DATA), 32'hFC);
    wr(21'h001004, 16'h0004);
    repeat (35) @(negedge clk);
    sync_d0("scan_sync_mod");
    chk("disp4_wraps", 32'(SEG_DATA), 32'h8E);
    proc_status = 4'd1;
    @(negedge clk);
    hif.HOST_ADD = 21'h000000;
    hif.HDI = 16'h7777;
    hif.HOST_nCS = 1'b0;
    hif.HOST_nWE = 1'b0;
    repeat (3) @(negedge clk);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_com", 32'(SEG_COM), 32'h3F);
    chk("mid_rst_seg", 32'(SEG_DATA), 32'h00);
    chk("mid_rst_hdo", 32'(hif.HDO), 32'h0000);
    chk("mid_rst_cfg", {31'b0, |cfg_dout}, 32'd0);
    @(negedge clk);
    nRESET = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_commit", {31'b0, |cfg_dout}, 32'd0);
    chk("busy_cmd", 32'(proc_cmd), 32'h0);
    hif.HOST_nWE = 1'b1;
    hif.HOST_nCS = 1'b1;
    repeat (3) @(negedge clk);
    wr(21'h000002, 16'h4242);
    chk("post_rst_wr", cfg_dout[31:0], 32'h42420000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
